// File: rtl/timer_pkg.sv
// timer_pkg: register map, reset values, FSM states and byte-merge helper for the APB timer
package timer_pkg;
    localparam logic [31:0] ADDR_BASE = 32'h2000_0000;
    localparam logic [7:0] TCR_OFF = 8'h00;
    localparam logic [7:0] TDR0_OFF = 8'h04;
    localparam logic [7:0] TDR1_OFF = 8'h08;
    localparam logic [7:0] TCMP0_OFF = 8'h0C;
    localparam logic [7:0] TCMP1_OFF = 8'h10;
    localparam logic [7:0] TIER_OFF = 8'h14;
    localparam logic [7:0] TISR_OFF = 8'h18;
    localparam int TCR_EN = 0;
    localparam int TCR_DIV_EN = 1;
    localparam int TCR_DIV_LO = 8;
    localparam int TCR_DIV_HI = 11;
    localparam logic [31:0] TCR_MASK = 32'h0000_0F03;
    localparam logic [31:0] TCR_RST = 32'h0000_0100;
    localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;
    localparam logic [3:0] DIV_MAX = 4'd8;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} apb_state_t;
    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        for (int i = 0; i < 4; i++) strb_merge[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    endfunction
endpackage

// File: rtl/apb_timer_ctrl_if.sv
// apb_timer_ctrl_if: APB bus signals between master and the timer slave
interface apb_timer_ctrl_if;
    logic psel;
    logic penable;
    logic pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0] pstrb;
    logic [31:0] prdata;
    logic pready;
    logic pslverr;
    modport master(output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
    modport slave(input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/timer_rdmux.sv
// timer_rdmux: combinational register read mux, zero when not enabled or unmapped
module timer_rdmux
    import timer_pkg::*;
(
    input logic rd_en,
    input logic hit,
    input logic [7:0] off,
    input logic [31:0] tcr,
    input logic [63:0] cnt,
    input logic [63:0] cmp,
    input logic tier,
    input logic tisr,
    output logic [31:0] rdata
);
    logic [31:0] sel;
    always_comb begin
        sel = '0;
        case (off)
            TCR_OFF: sel = tcr;
            TDR0_OFF: sel = cnt[31:0];
            TDR1_OFF: sel = cnt[63:32];
            TCMP0_OFF: sel = cmp[31:0];
            TCMP1_OFF: sel = cmp[63:32];
            TIER_OFF: sel = {31'd0, tier};
            TISR_OFF: sel = {31'd0, tisr};
            default: sel = '0;
        endcase
        rdata = (rd_en && hit) ? sel : '0;
    end
endmodule

// File: rtl/apb_timer_ctrl.sv
// apb_timer_ctrl: APB slave with timer register file, prescaler, 64-bit counter and compare interrupt
module apb_timer_ctrl
    import timer_pkg::*;
(
    input logic clk,
    input logic rst_n,
    apb_timer_ctrl_if.slave apb,
    output logic tim_int
);
    apb_state_t state;
    logic [31:0] tcr, tcr_new, wmerge;
    logic [63:0] cnt, cmp;
    logic tier, tisr;
    logic [7:0] div, div_term, off;
    logic hit, tick, match, rd_en, wr, tcr_err;
    logic we_tcr, we_tdr0, we_tdr1, we_tcmp0, we_tcmp1, we_tier, w1c;
    assign hit = apb.paddr[31:8] == ADDR_BASE[31:8];
    assign off = apb.paddr[7:0];
    assign tcr_new = strb_merge(tcr, apb.pwdata, apb.pstrb) & TCR_MASK;
    // divider settings are frozen while the timer runs
    assign tcr_err = apb.pwrite && hit && off == TCR_OFF &&
        (tcr_new[TCR_DIV_HI:TCR_DIV_LO] > DIV_MAX ||
         (tcr[TCR_EN] && {tcr_new[TCR_DIV_HI:TCR_DIV_LO], tcr_new[TCR_DIV_EN]} != {tcr[TCR_DIV_HI:TCR_DIV_LO], tcr[TCR_DIV_EN]}));
    assign wr = state == WAIT && apb.psel && apb.pwrite && hit && !apb.pslverr;
    assign we_tcr = wr && off == TCR_OFF;
    assign we_tdr0 = wr && off == TDR0_OFF;
    assign we_tdr1 = wr && off == TDR1_OFF;
    assign we_tcmp0 = wr && off == TCMP0_OFF;
    assign we_tcmp1 = wr && off == TCMP1_OFF;
    assign we_tier = wr && off == TIER_OFF && apb.pstrb[0];
    assign w1c = wr && off == TISR_OFF && apb.pstrb[0] && apb.pwdata[0];
    assign div_term = 8'((9'd1 << tcr[TCR_DIV_HI:TCR_DIV_LO]) - 9'd1);
    assign tick = !tcr[TCR_DIV_EN] || div == div_term;
    assign match = cnt == cmp;
    assign rd_en = apb.psel && !apb.pwrite && state == WAIT;
    assign tim_int = tier && tisr;
    always_comb begin
        wmerge = '0;
        case (off)
            TDR0_OFF: wmerge = strb_merge(cnt[31:0], apb.pwdata, apb.pstrb);
            TDR1_OFF: wmerge = strb_merge(cnt[63:32], apb.pwdata, apb.pstrb);
            TCMP0_OFF: wmerge = strb_merge(cmp[31:0], apb.pwdata, apb.pstrb);
            TCMP1_OFF: wmerge = strb_merge(cmp[63:32], apb.pwdata, apb.pstrb);
            default: wmerge = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            apb.pready <= 1'b0;
            apb.pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= apb.psel ? ACCESS : IDLE;
                ACCESS: begin
                    state <= (apb.psel && apb.penable) ? WAIT : IDLE;
                    apb.pready <= apb.psel && apb.penable;
                    apb.pslverr <= apb.psel && apb.penable && tcr_err;
                end
                default: begin
                    state <= IDLE;
                    apb.pready <= 1'b0;
                    apb.pslverr <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcr <= TCR_RST;
            cnt <= '0;
            cmp <= {TCMP_RST, TCMP_RST};
            tier <= 1'b0;
            tisr <= 1'b0;
            div <= '0;
        end else begin
            if (we_tcr) tcr <= tcr_new;
            if (we_tcmp0) cmp[31:0] <= wmerge;
            if (we_tcmp1) cmp[63:32] <= wmerge;
            if (we_tier) tier <= apb.pwdata[0];
            tisr <= match || (tisr && !w1c);
            div <= (!tcr[TCR_EN] || !tcr[TCR_DIV_EN] || tick) ? 8'd0 : div + 8'd1;
            if (we_tdr0) cnt[31:0] <= wmerge;
            else if (we_tdr1) cnt[63:32] <= wmerge;
            else if (tcr[TCR_EN] && tick) cnt <= cnt + 64'd1;
        end
    end
    timer_rdmux u_rdmux (
        .rd_en(rd_en),
        .hit(hit),
        .off(off),
        .tcr(tcr),
        .cnt(cnt),
        .cmp(cmp),
        .tier(tier),
        .tisr(tisr),
        .rdata(apb.prdata)
    );
endmodule

// File: tb/tb_apb_timer_ctrl.sv
// tb_apb_timer_ctrl: directed APB transfers against hand-computed timer register values
module tb_apb_timer_ctrl;
    import timer_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tim_int;
    int checks = 0;
    int errors = 0;
    apb_timer_ctrl_if apb();
    apb_timer_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .apb(apb.slave),
        .tim_int(tim_int)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err);
        apb.psel = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite = w;
        apb.paddr = ADDR_BASE + 32'(off);
        apb.pwdata = wd;
        apb.pstrb = w ? st : 4'h0;
        @(posedge clk); #1;
        chk("pready_access", 32'(apb.pready), 32'd0);
        apb.penable = 1'b1;
        @(posedge clk); #1;
        chk("pready_wait", 32'(apb.pready), 32'd1);
        rd = apb.prdata;
        err = apb.pslverr;
        @(posedge clk); #1;
        apb.psel = 1'b0;
        apb.penable = 1'b0;
    endtask
    task automatic wr_chk(input string tag, input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st, input logic exp_err);
        logic [31:0] rd;
        logic err;
        xfer(1'b1, off, wd, st, rd, err);
        chk(tag, 32'(err), 32'(exp_err));
    endtask
    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        xfer(1'b0, off, 32'd0, 4'h0, rd, err);
        chk(tag, rd, exp);
        chk("rd_slverr", 32'(err), 32'd0);
    endtask
    initial begin
        logic [31:0] v;
        logic e;
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite = 1'b0;
        apb.paddr = '0;
        apb.pwdata = '0;
        apb.pstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 32'(apb.pready), 32'd0);
        chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
        chk("rst_prdata", apb.prdata, 32'd0);
        chk("rst_tim_int", 32'(tim_int), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst_tcr", TCR_OFF, 32'h0000_0100);
        rd_chk("rst_tdr0", TDR0_OFF, 32'd0);
        rd_chk("rst_tdr1", TDR1_OFF, 32'd0);
        rd_chk("rst_tcmp0", TCMP0_OFF, 32'hFFFF_FFFF);
        rd_chk("rst_tcmp1", TCMP1_OFF, 32'hFFFF_FFFF);
        rd_chk("rst_tier", TIER_OFF, 32'd0);
        rd_chk("rst_tisr", TISR_OFF, 32'd0);
        rd_chk("unmapped", 8'h1C, 32'd0);
        chk("prdata_idle", apb.prdata, 32'd0);
        // low byte only: en + div_en, div_val keeps its reset value of 1
        wr_chk("tcr_div2_err", TCR_OFF, 32'h0000_0003, 4'b0001, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        xfer(1'b0, TDR0_OFF, 32'd0, 4'h0, v, e);
        chk("tdr0_div2_range", 32'(v >= 32'd9 && v <= 32'd11), 32'd1);
        wr_chk("tcr_stop_err", TCR_OFF, 32'h0000_0002, 4'b0001, 1'b0);
        wr_chk("tdr0_wr_err", TDR0_OFF, 32'hFFFF_FFFE, 4'hF, 1'b0);
        wr_chk("tdr1_wr_err", TDR1_OFF, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd_chk("tdr0_wr", TDR0_OFF, 32'hFFFF_FFFE);
        wr_chk("tcr_run_err", TCR_OFF, 32'h0000_0001, 4'hF, 1'b0);
        wr_chk("tcr_halt_err", TCR_OFF, 32'h0000_0000, 4'hF, 1'b0);
        rd_chk("wrap_tdr1", TDR1_OFF, 32'd0);
        rd_chk("wrap_tdr0", TDR0_OFF, 32'd1);
        rd_chk("wrap_match_tisr", TISR_OFF, 32'd1);
        wr_chk("tcmp1_wr_err", TCMP1_OFF, 32'd0, 4'hF, 1'b0);
        wr_chk("tcmp0_wr_err", TCMP0_OFF, 32'd5, 4'hF, 1'b0);
        wr_chk("tisr_clr_err", TISR_OFF, 32'd1, 4'hF, 1'b0);
        wr_chk("tier_wr_err", TIER_OFF, 32'd1, 4'hF, 1'b0);
        chk("tim_int_cleared", 32'(tim_int), 32'd0);
        wr_chk("tcr_cmp_run_err", TCR_OFF, 32'h0000_0001, 4'hF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("tim_int_match_cycle", 32'(tim_int), 32'd0);
        @(posedge clk); #1;
        chk("tim_int_after_match", 32'(tim_int), 32'd1);
        wr_chk("tcr_cmp_halt_err", TCR_OFF, 32'h0000_0000, 4'hF, 1'b0);
        rd_chk("tdr0_hold", TDR0_OFF, 32'd9);
        rd_chk("tisr_set", TISR_OFF, 32'd1);
        wr_chk("tisr_w1c_err", TISR_OFF, 32'd1, 4'hF, 1'b0);
        chk("tim_int_w1c", 32'(tim_int), 32'd0);
        // counter stopped at 9; matching it keeps the compare true every cycle
        wr_chk("tcmp0_eq_err", TCMP0_OFF, 32'd9, 4'hF, 1'b0);
        wr_chk("tisr_w1c2_err", TISR_OFF, 32'd1, 4'hF, 1'b0);
        chk("set_wins_int", 32'(tim_int), 32'd1);
        wr_chk("tier_off_err", TIER_OFF, 32'd0, 4'hF, 1'b0);
        chk("tier_mask", 32'(tim_int), 32'd0);
        rd_chk("tisr_masked", TISR_OFF, 32'd1);
        wr_chk("tcmp1_strb_err", TCMP1_OFF, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd_chk("tcmp1_strb", TCMP1_OFF, 32'h00BB_00DD);
        wr_chk("tcr_div9_err", TCR_OFF, 32'h0000_0900, 4'hF, 1'b1);
        rd_chk("tcr_div9_hold", TCR_OFF, 32'd0);
        wr_chk("tcr_en_err", TCR_OFF, 32'h0000_0001, 4'hF, 1'b0);
        wr_chk("tcr_live_div_err", TCR_OFF, 32'h0000_0201, 4'hF, 1'b1);
        rd_chk("tcr_live_hold", TCR_OFF, 32'h0000_0001);
        wr_chk("tcr_off_err", TCR_OFF, 32'h0000_0000, 4'hF, 1'b0);
        apb.psel = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite = 1'b1;
        apb.paddr = ADDR_BASE + 32'(TCMP0_OFF);
        apb.pwdata = 32'h0000_1234;
        apb.pstrb = 4'hF;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_pready_hi", 32'(apb.pready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pready_lo", 32'(apb.pready), 32'd0);
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst_mid_tcmp0", TCMP0_OFF, 32'hFFFF_FFFF);
        rd_chk("rst_mid_tcr", TCR_OFF, 32'h0000_0100);
        chk("rst_mid_tim_int", 32'(tim_int), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
